// File: rtl/pipeline_frontend_ctrl.sv
// rtl/pipeline_frontend_ctrl.sv - fetch/decode front-end control: PC, IF/ID, ID/EX ctrl, stall FSM, watchdog
// Branch redirect has priority over stall inputs; every output is registered.
module pipeline_frontend_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        IF_ID_Write,
   input  logic        ControlMux,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] instr_in,
   input  logic [7:0]  ctrl_in,
   output logic [31:0] pc,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic [7:0]  id_ex_ctrl,
   output logic [7:0]  stall_count,
   output logic        stall_timeout,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_RUN   = 2'b00,
      S_STALL = 2'b01,
      S_FLUSH = 2'b10
   } state_t;

   state_t     state_q;
   logic [4:0] run_cnt;

   assign state = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc            <= 32'h0;
         if_id_pc      <= 32'h0;
         if_id_instr   <= 32'h0;
         if_id_valid   <= 1'b0;
         id_ex_ctrl    <= 8'h00;
         stall_count   <= 8'h00;
         stall_timeout <= 1'b0;
         run_cnt       <= 5'd0;
         state_q       <= S_RUN;
      end else if (branch_taken) begin
         // Redirect squashes the fetched instruction and the decode slot.
         pc          <= branch_target & 32'hFFFF_FFFC;
         if_id_instr <= 32'h0;
         if_id_valid <= 1'b0;
         id_ex_ctrl  <= 8'h00;
         run_cnt     <= 5'd0;
         state_q     <= S_FLUSH;
      end else begin
         if (PCWrite)
            pc <= pc + 32'd4;
         if (IF_ID_Write) begin
            if_id_instr <= instr_in;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
         end
         id_ex_ctrl <= ControlMux ? 8'h00 : ctrl_in;
         if (ControlMux) begin
            if (stall_count != 8'hFF)
               stall_count <= stall_count + 8'd1;
            // Counter holds at 16 once reached; the flag itself is sticky.
            if (run_cnt != 5'd16)
               run_cnt <= run_cnt + 5'd1;
            if (run_cnt >= 5'd15)
               stall_timeout <= 1'b1;
            state_q <= S_STALL;
         end else begin
            run_cnt <= 5'd0;
            state_q <= S_RUN;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_frontend_ctrl.sv
// tb/tb_pipeline_frontend_ctrl.sv - self-checking bench for pipeline_frontend_ctrl
// Directed scenarios plus randomized traffic against a behavioural reference model.
module tb_pipeline_frontend_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        PCWrite = 1'b0;
   logic        IF_ID_Write = 1'b0;
   logic        ControlMux = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] instr_in = 32'h0;
   logic [7:0]  ctrl_in = 8'h0;
   logic [31:0] pc, if_id_pc, if_id_instr;
   logic        if_id_valid, stall_timeout;
   logic [7:0]  id_ex_ctrl, stall_count;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   longint      m_pc, m_ifpc;
   logic [31:0] m_ifinstr;
   logic        m_ifvalid, m_to;
   logic [7:0]  m_ctrl;
   int          m_cnt, m_run, m_state;

   pipeline_frontend_ctrl dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
      .ControlMux(ControlMux), .branch_taken(branch_taken), .branch_target(branch_target),
      .instr_in(instr_in), .ctrl_in(ctrl_in), .pc(pc), .if_id_pc(if_id_pc),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .id_ex_ctrl(id_ex_ctrl),
      .stall_count(stall_count), .stall_timeout(stall_timeout), .state(state)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc = 0; m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0; m_ctrl = 0;
      m_cnt = 0; m_run = 0; m_to = 0; m_state = 0;
   endtask

   task automatic model_edge();
      if (branch_taken) begin
         m_pc = branch_target / 4 * 4;
         m_ifinstr = 0; m_ifvalid = 0; m_ctrl = 0; m_run = 0; m_state = 2;
      end else begin
         if (IF_ID_Write) begin
            m_ifinstr = instr_in; m_ifpc = m_pc; m_ifvalid = 1;
         end
         if (PCWrite) m_pc = (m_pc + 4) % 64'h1_0000_0000;
         m_ctrl = ControlMux ? 8'h00 : ctrl_in;
         if (ControlMux) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_run = m_run + 1;
            if (m_run >= 16) m_to = 1;
            m_state = 1;
         end else begin
            m_run = 0;
            m_state = 0;
         end
      end
   endtask

   task automatic drive(input logic pcw, input logic ifw, input logic cm, input logic bt,
                        input logic [31:0] tgt, input logic [31:0] ins, input logic [7:0] ct);
      PCWrite = pcw; IF_ID_Write = ifw; ControlMux = cm; branch_taken = bt;
      branch_target = tgt; instr_in = ins; ctrl_in = ct;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_tests++;
      if ({pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, stall_count, stall_timeout, state} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got pc=%h ifpc=%h ins=%h v=%b ctrl=%h cnt=%h to=%b st=%0d exp all zero",
                  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, stall_count, stall_timeout, state);
      end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      logic [31:0] exp_pc;
      logic [31:0] exp_ifpc;
      do_reset();
      drive(1, 1, 0, 0, 0, 32'h1111_1111, 8'h5A);
      for (int i = 1; i <= 3; i++) begin
         step();
         exp_pc = 4 * i;
         exp_ifpc = 4 * (i - 1);
         n_tests++;
         if (pc !== exp_pc || if_id_pc !== exp_ifpc || if_id_valid !== 1'b1 ||
             if_id_instr !== 32'h1111_1111 || id_ex_ctrl !== 8'h5A) begin
            n_fail++;
            $display("FAIL free_run[%0d] got pc=%h ifpc=%h v=%b ins=%h ctrl=%h exp pc=%h ifpc=%h v=1 ins=11111111 ctrl=5a",
                     i, pc, if_id_pc, if_id_valid, if_id_instr, id_ex_ctrl, exp_pc, exp_ifpc);
         end
      end
   endtask

   task automatic test_single_stall();
      // continue from free run: one more cycle brings pc to 0x10
      drive(1, 1, 0, 0, 0, 32'h2222_2222, 8'h33);
      step();
      n_tests++;
      if (pc !== 32'h10) begin
         n_fail++; $display("FAIL stall_setup_pc got %h exp 00000010", pc);
      end
      drive(0, 0, 1, 0, 0, 32'hDEAD_BEEF, 8'hFF);
      step();
      n_tests++;
      if (pc !== 32'h10 || if_id_pc !== 32'hC || if_id_instr !== 32'h2222_2222 || if_id_valid !== 1'b1 ||
          id_ex_ctrl !== 8'h00 || state !== 2'b01 || stall_count !== 8'd1) begin
         n_fail++;
         $display("FAIL single_stall got pc=%h ifpc=%h ins=%h v=%b ctrl=%h st=%0d cnt=%0d exp pc=10 ifpc=c ins=22222222 v=1 ctrl=0 st=1 cnt=1",
                  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, state, stall_count);
      end
      drive(1, 1, 0, 0, 0, 32'h3333_3333, 8'h44);
      step();
      n_tests++;
      if (state !== 2'b00 || pc !== 32'h14 || if_id_pc !== 32'h10 || id_ex_ctrl !== 8'h44) begin
         n_fail++;
         $display("FAIL stall_release got st=%0d pc=%h ifpc=%h ctrl=%h exp st=0 pc=14 ifpc=10 ctrl=44",
                  state, pc, if_id_pc, id_ex_ctrl);
      end
   endtask

   task automatic test_branch_in_stall();
      logic [7:0] cnt_before;
      drive(0, 0, 1, 0, 0, 0, 8'h12);
      step();
      cnt_before = stall_count;
      n_tests++;
      if (state !== 2'b01 || stall_count !== 8'd2) begin
         n_fail++; $display("FAIL branch_pre_stall got st=%0d cnt=%0d exp st=1 cnt=2", state, stall_count);
      end
      drive(0, 0, 1, 1, 32'h203, 32'h7777_7777, 8'h99);
      step();
      n_tests++;
      if (pc !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || id_ex_ctrl !== 8'h00 ||
          state !== 2'b10 || stall_count !== 8'd2) begin
         n_fail++;
         $display("FAIL branch_in_stall got pc=%h v=%b ins=%h ctrl=%h st=%0d cnt=%0d exp pc=200 v=0 ins=0 ctrl=0 st=2 cnt=%0d",
                  pc, if_id_valid, if_id_instr, id_ex_ctrl, state, stall_count, cnt_before);
      end
      drive(1, 1, 0, 0, 0, 32'h8888_8888, 8'h21);
      step();
      n_tests++;
      if (state !== 2'b00 || pc !== 32'h204 || if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_exit got st=%0d pc=%h ifpc=%h v=%b exp st=0 pc=204 ifpc=200 v=1",
                  state, pc, if_id_pc, if_id_valid);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      drive(0, 0, 1, 0, 0, 0, 8'h0F);
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 15 || i == 16) begin
            n_tests++;
            if (stall_timeout !== (i == 16)) begin
               n_fail++;
               $display("FAIL watchdog_edge%0d got to=%b exp %b", i, stall_timeout, (i == 16));
            end
         end
      end
      drive(1, 1, 0, 0, 0, 0, 8'h0F);
      repeat (3) step();
      n_tests++;
      if (stall_timeout !== 1'b1 || stall_count !== 8'd16 || state !== 2'b00) begin
         n_fail++;
         $display("FAIL watchdog_sticky got to=%b cnt=%0d st=%0d exp to=1 cnt=16 st=0", stall_timeout, stall_count, state);
      end
   endtask

   task automatic test_saturation_wrap();
      do_reset();
      drive(0, 0, 1, 0, 0, 0, 0);
      repeat (300) step();
      n_tests++;
      if (stall_count !== 8'hFF) begin
         n_fail++; $display("FAIL stall_saturate got %h exp ff", stall_count);
      end
      drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      step();
      n_tests++;
      if (pc !== 32'hFFFF_FFFC || stall_count !== 8'hFF) begin
         n_fail++; $display("FAIL wrap_branch got pc=%h cnt=%h exp pc=fffffffc cnt=ff", pc, stall_count);
      end
      drive(1, 1, 0, 0, 0, 32'hABCD_0000, 0);
      step();
      n_tests++;
      if (pc !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL wrap_pc0 got pc=%h ifpc=%h exp pc=0 ifpc=fffffffc", pc, if_id_pc);
      end
      step();
      n_tests++;
      if (pc !== 32'h4) begin
         n_fail++; $display("FAIL wrap_pc4 got pc=%h exp 00000004", pc);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1, 1, 0, 0, 0, 32'h5555_5555, 8'h66);
      repeat (3) step();
      drive(0, 0, 1, 0, 0, 0, 0);
      repeat (2) step();
      n_tests++;
      if (state !== 2'b01 || pc !== 32'hC) begin
         n_fail++; $display("FAIL areset_setup got st=%0d pc=%h exp st=1 pc=c", state, pc);
      end
      #2 reset = 1'b1;
      #1;
      model_reset();
      n_tests++;
      if ({pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, stall_count, stall_timeout, state} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got pc=%h ifpc=%h ins=%h v=%b ctrl=%h cnt=%h to=%b st=%0d exp all zero",
                  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, stall_count, stall_timeout, state);
      end
      #1 reset = 1'b0;
      drive(1, 1, 0, 0, 0, 32'h9999_9999, 8'h01);
      step();
      n_tests++;
      if (pc !== 32'h4 || if_id_pc !== 32'h0 || state !== 2'b00 || if_id_instr !== 32'h9999_9999) begin
         n_fail++;
         $display("FAIL reset_resume got pc=%h ifpc=%h st=%0d ins=%h exp pc=4 ifpc=0 st=0 ins=99999999",
                  pc, if_id_pc, state, if_id_instr);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 9) == 0), $urandom, $urandom, 8'($urandom));
         step();
         n_tests++;
         if (pc !== m_pc[31:0] || if_id_pc !== m_ifpc[31:0] || if_id_instr !== m_ifinstr ||
             if_id_valid !== m_ifvalid || id_ex_ctrl !== m_ctrl || stall_count !== 8'(m_cnt) ||
             stall_timeout !== m_to || state !== 2'(m_state)) begin
            n_fail++;
            $display("FAIL random[%0d] got pc=%h ifpc=%h ins=%h v=%b ctrl=%h cnt=%h to=%b st=%0d exp pc=%h ifpc=%h ins=%h v=%b ctrl=%h cnt=%h to=%b st=%0d",
                     c, pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, stall_count, stall_timeout, state,
                     m_pc[31:0], m_ifpc[31:0], m_ifinstr, m_ifvalid, m_ctrl, 8'(m_cnt), m_to, m_state);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_single_stall();
      test_branch_in_stall();
      test_watchdog();
      test_saturation_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_frontend_ctrl.md
PIPELINE_FRONTEND_CTRL -- requirements
Module: pipeline_frontend_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- PCWrite  in  1  1 = PC may advance; 0 = hold PC
- IF_ID_Write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- ControlMux  in  1  1 = insert bubble into ID/EX control
- branch_taken  in  1  redirect request from EX
- branch_target  in  32  redirect address
- instr_in  in  32  instruction-memory data at pc
- ctrl_in  in  8  decoded control bits for the IF/ID instruction
- pc  out  32  current fetch address
- if_id_pc  out  32  PC of the instruction held in IF/ID
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- id_ex_ctrl  out  8  registered control bits to EX
- stall_count  out  8  total stall cycles, saturating
- stall_timeout  out  1  sticky watchdog flag
- state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH

Function
REQ-003 The FSM SHALL have the states RUN, STALL and FLUSH, and all state and outputs SHALL update on the rising edge of clk only.
REQ-004 The priority order SHALL be: reset, then branch_taken, then stall inputs, then normal advance.
REQ-005 On branch_taken=1 in any state:
- pc <= {branch_target[31:2],2'b00}
- if_id_instr <= 0, if_id_valid <= 0
- id_ex_ctrl <= 0
- next state FLUSH
- PCWrite, IF_ID_Write and ControlMux SHALL be ignored that cycle.
REQ-006 In FLUSH, the block SHALL behave as RUN for the PC, IF/ID and ID/EX updates, and the next state SHALL be STALL if ControlMux=1, else RUN; FLUSH SHALL last exactly 1 cycle unless branch_taken repeats.
REQ-007 With no branch and PCWrite=1, the update SHALL be pc <= pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); with PCWrite=0, pc SHALL hold.
REQ-008 With no branch and IF_ID_Write=1, the update SHALL be: if_id_instr <= instr_in, if_id_pc <= pc, if_id_valid <= 1; with IF_ID_Write=0, all three SHALL hold.
REQ-009 With no branch, id_ex_ctrl SHALL take 8'h00 when ControlMux=1, else ctrl_in.
REQ-010 State transitions:
- RUN -> STALL when ControlMux=1.
- STALL -> RUN when ControlMux=0.
- STALL -> STALL while ControlMux=1.
REQ-011 stall_count SHALL increment by 1 on every non-branch cycle with ControlMux=1 and SHALL saturate at 8'hFF.
REQ-012 An internal 5-bit run counter SHALL:
- count consecutive cycles in STALL;
- clear on leaving STALL or on branch_taken;
- set stall_timeout <= 1 when it reaches 16.
stall_timeout SHALL remain 1 until reset.
REQ-013 The PCWrite and IF_ID_Write inputs SHALL be honoured independently, including mismatched combinations (e.g. PCWrite=1, IF_ID_Write=0: PC advances, IF/ID holds).
REQ-014 No output SHALL depend combinationally on any input; all outputs SHALL be registered.

Reset
REQ-015 While reset=1, the block SHALL asynchronously force:
- pc=0, if_id_pc=0, if_id_instr=0, if_id_valid=0
- id_ex_ctrl=0, stall_count=0, stall_timeout=0
- run counter=0, state=RUN
REQ-016 Reset asserted mid-stall or mid-flush SHALL abandon that operation, and the first rising edge after deassertion SHALL behave as RUN from pc=0.

Verification
REQ-017 The bench SHALL cover free run: reset release, then PCWrite=IF_ID_Write=1, ControlMux=0, instr_in=0x11111111 for 3 cycles -> pc 4, 8, 12; if_id_pc 0, 4, 8; if_id_valid=1.
REQ-018 The bench SHALL cover a single stall: pc=0x10, then PCWrite=IF_ID_Write=0, ControlMux=1 for 1 cycle -> pc stays 0x10, IF/ID holds, id_ex_ctrl=0, state=STALL, stall_count=1; the next normal cycle -> state=RUN, pc=0x14.
REQ-019 The bench SHALL cover branch during stall: ControlMux=1 with branch_taken=1, branch_target=0x203 -> pc=0x200, if_id_valid=0, id_ex_ctrl=0, state=FLUSH, stall_count unchanged.
REQ-020 The bench SHALL cover the watchdog: ControlMux=1 for 16 consecutive cycles -> stall_timeout=1 at the 16th edge; ControlMux=0 afterwards -> stall_timeout stays 1, stall_count=16.
REQ-021 The bench SHALL cover saturation and wrap:
- 300 stall cycles -> stall_count=0xFF.
- branch to 0xFFFFFFFC, then 2 normal cycles -> pc=0x00000000, then 0x00000004.
REQ-022 The bench SHALL cover asynchronous reset: assert reset between clock edges during STALL -> all outputs are zero and state=RUN before the next edge.
